// File: rtl/rst_release_seq_if.sv
// Control/status bundle of the reset-release sequencer: software reset and
// hold requests in, staged domain resets and status out.
interface rst_release_seq_if #(
    parameter int unsigned N_DOMAINS = 4
);
    logic                               SW_RST_REQ;
    logic                               HOLD;
    logic [N_DOMAINS-1:0]               RN_OUT;
    logic                               RDY;
    logic [$clog2(N_DOMAINS+1)-1:0]     REL_CNT;
    logic [7:0]                         SW_RST_CNT;

    modport master (
        input  SW_RST_REQ,
        input  HOLD,
        output RN_OUT,
        output RDY,
        output REL_CNT,
        output SW_RST_CNT
    );

    modport slave (
        output SW_RST_REQ,
        output HOLD,
        input  RN_OUT,
        input  RDY,
        input  REL_CNT,
        input  SW_RST_CNT
    );
endinterface

// File: rtl/rst_release_seq.sv
// Reset-release sequencer: asynchronous assertion from RN, synchronised and
// staged deassertion of per-domain active-low resets, with software re-run.
module rst_release_seq #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned N_DOMAINS   = 4,
    parameter int unsigned GAP         = 8,
    parameter int unsigned SW_PULSE    = 16
) (
    input  logic              CK,
    input  logic              RN,
    rst_release_seq_if.master bus
);

    localparam int unsigned CNT_MAX = (GAP > SW_PULSE) ? GAP : SW_PULSE;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned RW      = $clog2(N_DOMAINS + 1);

    typedef enum logic [2:0] {
        S_RESET,
        S_SYNC,
        S_STAGE,
        S_DONE,
        S_SWRST
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [N_DOMAINS-1:0]   rn_out_q, rn_out_d;
    logic                   rdy_q, rdy_d;
    logic [RW-1:0]          rel_cnt_q, rel_cnt_d;
    logic [7:0]             sw_cnt_q, sw_cnt_d;

    logic sync_out;
    logic gap_done;
    logic pulse_done;
    logic all_rel;
    logic sw_req;

    assign sync_out   = sync_q[SYNC_STAGES-1];
    assign gap_done   = (cnt_q == CW'(GAP - 1));
    assign pulse_done = (cnt_q == CW'(SW_PULSE - 1));
    assign all_rel    = (rel_cnt_q == RW'(N_DOMAINS));
    assign sw_req     = bus.SW_RST_REQ && (state_q != S_RESET);

    // RN deassertion synchroniser; assertion clears the chain asynchronously.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q   <= S_RESET;
            cnt_q     <= '0;
            rn_out_q  <= '0;
            rdy_q     <= 1'b0;
            rel_cnt_q <= '0;
            sw_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rn_out_q  <= rn_out_d;
            rdy_q     <= rdy_d;
            rel_cnt_q <= rel_cnt_d;
            sw_cnt_q  <= sw_cnt_d;
        end
    end

    // The SYNC edge counts as the first of the GAP edges after bit 0, so
    // SYNC and STAGE share one step rule (the counter is 0 in SYNC).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (sw_req) begin
            state_d = S_SWRST;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_RESET: begin
                    if (sync_out) begin
                        state_d = S_SYNC;
                    end
                end
                S_SYNC, S_STAGE: begin
                    if (!bus.HOLD) begin
                        if (gap_done) begin
                            cnt_d   = '0;
                            state_d = all_rel ? S_DONE : S_STAGE;
                        end else begin
                            cnt_d   = cnt_q + 1'b1;
                            state_d = S_STAGE;
                        end
                    end
                end
                S_SWRST: begin
                    if (pulse_done) begin
                        cnt_d   = '0;
                        state_d = S_STAGE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_RESET;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        rn_out_d  = rn_out_q;
        rdy_d     = rdy_q;
        rel_cnt_d = rel_cnt_q;
        sw_cnt_d  = sw_cnt_q;
        if (sw_req) begin
            rn_out_d  = '0;
            rdy_d     = 1'b0;
            rel_cnt_d = '0;
            if (sw_cnt_q != 8'hFF) begin
                sw_cnt_d = sw_cnt_q + 8'd1;
            end
        end else begin
            case (state_q)
                S_RESET: begin
                    if (sync_out) begin
                        rn_out_d  = N_DOMAINS'(1);
                        rel_cnt_d = RW'(1);
                    end
                end
                S_SYNC, S_STAGE: begin
                    if (!bus.HOLD && gap_done) begin
                        if (all_rel) begin
                            rdy_d = 1'b1;
                        end else begin
                            rn_out_d  = (rn_out_q << 1) | N_DOMAINS'(1);
                            rel_cnt_d = rel_cnt_q + 1'b1;
                        end
                    end
                end
                S_SWRST: begin
                    if (pulse_done) begin
                        rn_out_d  = N_DOMAINS'(1);
                        rel_cnt_d = RW'(1);
                    end
                end
                default: begin
                    rn_out_d = rn_out_q;
                end
            endcase
        end
    end

    assign bus.RN_OUT     = rn_out_q;
    assign bus.RDY        = rdy_q;
    assign bus.REL_CNT    = rel_cnt_q;
    assign bus.SW_RST_CNT = sw_cnt_q;

endmodule
